// File: rtl/psr_cond_unit_pkg.sv
// Shared definitions for the PSR / condition-code unit: flag bit map, condition codes and
// shadow-state encoding.
package psr_cond_unit_pkg;

    localparam int PSR_W  = 5;
    localparam int COND_W = 4;

    // Flag bit positions within the PSR, {N,Z,F,L,C} = [4:0]
    localparam int PSR_C = 0;
    localparam int PSR_L = 1;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;

    typedef enum logic [COND_W-1:0] {
        COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
        COND_HI = 4'd4,  COND_LS = 4'd5,  COND_GT = 4'd6,  COND_LE = 4'd7,
        COND_FS = 4'd8,  COND_FC = 4'd9,  COND_LO = 4'd10, COND_HS = 4'd11,
        COND_LT = 4'd12, COND_GE = 4'd13, COND_UC = 4'd14, COND_NV = 4'd15
    } condCode_e;

    typedef enum logic {
        SH_IDLE = 1'b0,
        SH_HELD = 1'b1
    } shadowState_e;

    // Apply a masked ALU flag write on top of the current flags
    function automatic logic [PSR_W-1:0] mergeFlags(
        input logic [PSR_W-1:0] oldFlags,
        input logic [PSR_W-1:0] newFlags,
        input logic [PSR_W-1:0] writeMask
    );
        return (oldFlags & ~writeMask) | (newFlags & writeMask);
    endfunction

endpackage

// File: rtl/psr_cond_unit_cond_eval.sv
// Combinational condition-code evaluator: flags + 4-bit code -> condition true.
// Shared with the Scond decode path, so it holds no state.
module cond_eval
    import psr_cond_unit_pkg::*;
(
    input  logic [PSR_W-1:0]  flags,
    input  logic [COND_W-1:0] code,
    output logic              isTrue
);

    logic flagC, flagL, flagF, flagZ, flagN;

    assign flagC = flags[PSR_C];
    assign flagL = flags[PSR_L];
    assign flagF = flags[PSR_F];
    assign flagZ = flags[PSR_Z];
    assign flagN = flags[PSR_N];

    always_comb begin
        // NOTE: default assigned before the case so no path through this block infers a latch.
        isTrue = 1'b0;
        case (condCode_e'(code))
            COND_EQ: isTrue = flagZ;
            COND_NE: isTrue = !flagZ;
            COND_CS: isTrue = flagC;
            COND_CC: isTrue = !flagC;
            COND_HI: isTrue = flagL;
            COND_LS: isTrue = !flagL;
            COND_GT: isTrue = flagN;
            COND_LE: isTrue = !flagN;
            COND_FS: isTrue = flagF;
            COND_FC: isTrue = !flagF;
            COND_LO: isTrue = !flagZ && !flagL;
            COND_HS: isTrue = flagZ || flagL;
            COND_LT: isTrue = !flagZ && !flagN;
            COND_GE: isTrue = flagZ || flagN;
            COND_UC: isTrue = 1'b1;
            COND_NV: isTrue = 1'b0;
            default: isTrue = 1'b0;
        endcase
    end

endmodule

// File: rtl/psr_cond_unit.sv
// Architectural PSR with masked ALU flag writes, a one-deep interrupt shadow, and a
// registered condition-code query pipe for the branch unit.
module psr_cond_unit
    import psr_cond_unit_pkg::*;
#(
    parameter int PSRW   = PSR_W,
    parameter int CONDW  = COND_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PSRW-1:0]  flagIn,
    input  logic [PSRW-1:0]  flagWe,
    input  logic             aluValid,
    input  logic             intEntry,
    input  logic             intReturn,
    input  logic             condValid,
    input  logic [CONDW-1:0] condCode,
    output logic [PSRW-1:0]  psr,
    output logic             condDone,
    output logic             condTrue,
    output logic             shadowVld
);

    shadowState_e    state, stateNext;
    logic [PSRW-1:0] shadow, shadowNext, psrNext;
    logic [PSRW-1:0] updFlags, effFlags;
    logic            condResult;

    // updFlags equals psr whenever no ALU write is pending
    assign updFlags = aluValid ? mergeFlags(psr, flagIn, flagWe) : psr;
    assign effFlags = BYPASS ? updFlags : psr;

    cond_eval u_condEval (
        .flags  (effFlags),
        .code   (condCode),
        .isTrue (condResult)
    );

    always_comb begin
        stateNext  = state;
        psrNext    = updFlags;
        shadowNext = shadow;
        if (intReturn && state == SH_HELD) begin
            psrNext   = shadow;
            stateNext = SH_IDLE;
        end else if (intEntry) begin
            // A nested entry keeps the original snapshot but still clears the live PSR
            psrNext = '0;
            if (state == SH_IDLE) begin
                shadowNext = updFlags;
                stateNext  = SH_HELD;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
        if (reset) begin
            state  <= SH_IDLE;
            psr    <= '0;
            shadow <= '0;
        end else begin
            state  <= stateNext;
            psr    <= psrNext;
            shadow <= shadowNext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            condDone <= 1'b0;
            condTrue <= 1'b0;
        end else begin
            condDone <= condValid;
            if (condValid) condTrue <= condResult;
        end
    end

    assign shadowVld = (state == SH_HELD);

endmodule
